mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one backing memory port between the instruction cache (line refills) and the data cache (line refills plus write-through stores).
- Sits in the memory subsystem between both caches and the unified memory model.
- Grants one transaction at a time and latches its command.
- Routes the response to the owner; handles instruction-fetch aborts and starvation of the instruction side.

Parameters:
- ADDR_W, 32, byte-address width.
- LINE_W, 128, refill line width in bits (same for both caches).
- WORD_W, 32, write-through data width.
- STARVE_MAX, 4, consecutive data grants allowed while an instruction request waits.

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous active-high reset
- i_readmiss  in  1  icache refill request, level, held until i_readready or abort
- i_abort  in  1  icache cancels current fetch (branch mispredict)
- i_addr  in  ADDR_W  icache refill address
- i_readready  out  1  one-cycle pulse, i_data valid
- i_data  out  LINE_W  refill line to icache
- d_readmiss  in  1  dcache refill request, level
- d_writethru  in  1  dcache write-through request, level
- d_addr  in  ADDR_W  dcache address
- d_wdata  in  WORD_W  write-through data
- d_readready  out  1  one-cycle pulse, d_data valid
- d_writeready  out  1  one-cycle pulse, write committed
- d_data  out  LINE_W  refill line to dcache
- mem_req  out  1  command valid, held until mem_ready
- mem_we  out  1  1 = word write, 0 = line read
- mem_addr  out  ADDR_W  latched command address
- mem_wdata  out  WORD_W  latched write data
- mem_ready  in  1  one-cycle pulse, transaction complete
- mem_rdata  in  LINE_W  read line, valid with mem_ready
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, all ready pulses, i_data, d_data, busy. Starve counter 0, mask 0.
- Rst mid-transaction returns to IDLE immediately. Any later mem_ready is ignored while in IDLE.
- States: IDLE, I_RD, D_RD, D_WR, I_DRAIN.
- Grant in IDLE, evaluated every cycle, with masked requesters excluded:
  - If d_writethru: go to D_WR. Writes beat reads inside the dcache side.
  - Else if d_readmiss: go to D_RD.
  - Else if i_readmiss and not i_abort: go to I_RD.
  - If starve_cnt == STARVE_MAX and i_readmiss is valid, the icache wins over the dcache.
  - On grant: latch mem_addr from the winner and mem_wdata = d_wdata (D_WR only). Set mem_we = (D_WR).
  - mem_req rises in the cycle after the grant decision, i.e. registered, at the same time as the state.
- starve_cnt:
  - Increments on each data grant made while i_readmiss is high (saturates at STARVE_MAX).
  - Clears on any instruction grant or when i_readmiss is low in IDLE.
- Busy states: mem_req held 1 with a stable command until the mem_ready cycle. Then:
  - I_RD: i_readready = 1 and i_data = mem_rdata, registered, for exactly 1 cycle after mem_ready.
  - D_RD: d_readready and d_data the same way.
  - D_WR: d_writeready pulses for 1 cycle.
  - mem_req drops in the same registered update. State returns to IDLE.
  - i_data and d_data hold their last value between pulses.
- Re-grant guard: the requester just served is masked for the IDLE cycle that coincides with its ready pulse. This prevents a double grant before the cache deasserts its level request.
- Abort:
  - i_abort in IDLE: the instruction request is not granted that cycle.
  - i_abort in I_RD: go to I_DRAIN. mem_req stays 1 (memory cannot cancel).
  - In I_DRAIN, mem_ready completes the read silently, with no i_readready, then returns to IDLE.
  - Abort while the dcache owns memory has no effect.
- Simultaneous d_readmiss and d_writethru: the write is served first and the read is granted afterwards.
- Minimum transaction latency is request-to-ready = mem latency + 2 cycles (grant register + response register).
- A mem_ready seen in IDLE is ignored.

Test Plan:
- Reset mid-D_RD (assert Rst 2 cycles after grant) -> mem_req = 0, busy = 0 immediately. A later mem_ready produces no d_readready.
- Single icache miss, i_addr = 0x00400040, memory returns 0xAAAA…AA after 5 cycles -> mem_req high 1 cycle after request, mem_we = 0, mem_addr = 0x00400040. One i_readready pulse with i_data = 0xAAAA…AA. Back to IDLE.
- Same-cycle i_readmiss, d_readmiss (0x10010000), and d_writethru (0x10010004, 0xDEADBEEF) -> order D_WR, then D_RD, then I_RD. d_writeready, then d_readready, then i_readready, each 1 pulse. mem_wdata = 0xDEADBEEF on the write.
- i_readmiss held while d_readmiss is re-asserted continuously -> after 4 data grants, the next grant is I_RD.
- i_abort pulsed in I_RD 2 cycles after grant -> state I_DRAIN, mem_req stays high until mem_ready. No i_readready is produced. A pending d_readmiss is granted on the next IDLE cycle.
- Cache holds d_readmiss one cycle past d_readready -> exactly one memory transaction is issued (guard mask).

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one backing memory port between icache refills and dcache refills/write-throughs.
// Commands and responses are registered; icache aborts drain the in-flight read silently.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 128,
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_readmiss,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_readready,
    output logic [LINE_W-1:0] i_data,
    input  logic              d_readmiss,
    input  logic              d_writethru,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_readready,
    output logic              d_writeready,
    output logic [LINE_W-1:0] d_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_RD    = 3'd1,
        D_RD    = 3'd2,
        D_WR    = 3'd3,
        I_DRAIN = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                i_readready_q, i_readready_d;
    logic                d_readready_q, d_readready_d;
    logic                d_writeready_q, d_writeready_d;
    logic [LINE_W-1:0]   i_data_q, i_data_d;
    logic [LINE_W-1:0]   d_data_q, d_data_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    // mask bit 0: icache read, bit 1: dcache read, bit 2: dcache write
    logic [2:0]          mask_q, mask_d;

    logic i_req_s, d_rd_s, d_wr_s, starved_s;

    assign i_req_s   = i_readmiss && !i_abort && !mask_q[0];
    assign d_rd_s    = d_readmiss && !mask_q[1];
    assign d_wr_s    = d_writethru && !mask_q[2];
    assign starved_s = (starve_cnt_q == CNT_W'(STARVE_MAX));

    // State register and all registered outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= {ADDR_W{1'b0}};
            mem_wdata_q    <= {WORD_W{1'b0}};
            i_readready_q  <= 1'b0;
            d_readready_q  <= 1'b0;
            d_writeready_q <= 1'b0;
            i_data_q       <= {LINE_W{1'b0}};
            d_data_q       <= {LINE_W{1'b0}};
            busy_q         <= 1'b0;
            starve_cnt_q   <= {CNT_W{1'b0}};
            mask_q         <= 3'b000;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            i_readready_q  <= i_readready_d;
            d_readready_q  <= d_readready_d;
            d_writeready_q <= d_writeready_d;
            i_data_q       <= i_data_d;
            d_data_q       <= d_data_d;
            busy_q         <= busy_d;
            starve_cnt_q   <= starve_cnt_d;
            mask_q         <= mask_d;
        end
    end

    // Grant selection, command latching and response routing
    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        i_readready_d  = 1'b0;
        d_readready_d  = 1'b0;
        d_writeready_d = 1'b0;
        i_data_d       = i_data_q;
        d_data_d       = d_data_q;
        starve_cnt_d   = starve_cnt_q;
        mask_d         = 3'b000;

        case (state_q)
            IDLE: begin
                if (i_req_s && starved_s) begin
                    state_d    = I_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
                end else if (d_wr_s) begin
                    state_d     = D_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (d_rd_s) begin
                    state_d    = D_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = d_addr;
                end else if (i_req_s) begin
                    state_d    = I_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
                end else begin
                    state_d = IDLE;
                end

                // Count data grants that bypass a waiting icache request
                if (!i_readmiss || state_d == I_RD) begin
                    starve_cnt_d = {CNT_W{1'b0}};
                end else if ((state_d == D_WR || state_d == D_RD) && !starved_s) begin
                    starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end else begin
                    starve_cnt_d = starve_cnt_q;
                end
            end
            I_RD: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mask_d    = 3'b001;
                    if (!i_abort) begin
                        i_readready_d = 1'b1;
                        i_data_d      = mem_rdata;
                    end else begin
                        i_readready_d = 1'b0;
                    end
                end else if (i_abort) begin
                    state_d = I_DRAIN;
                end else begin
                    state_d = I_RD;
                end
            end
            D_RD: begin
                if (mem_ready) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    mask_d        = 3'b010;
                    d_readready_d = 1'b1;
                    d_data_d      = mem_rdata;
                end else begin
                    state_d = D_RD;
                end
            end
            D_WR: begin
                if (mem_ready) begin
                    state_d        = IDLE;
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    mask_d         = 3'b100;
                    d_writeready_d = 1'b1;
                end else begin
                    state_d = D_WR;
                end
            end
            I_DRAIN: begin
                // Memory cannot cancel; swallow the response without a ready pulse
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mask_d    = 3'b001;
                end else begin
                    state_d = I_DRAIN;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign i_readready  = i_readready_q;
    assign i_data       = i_data_q;
    assign d_readready  = d_readready_q;
    assign d_writeready = d_writeready_q;
    assign d_data       = d_data_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected commands/responses,
// a monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;
    localparam int ADDR_W = 32, LINE_W = 128, WORD_W = 32, STARVE_MAX = 4;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              i_readmiss = 1'b0, i_abort = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_readready;
    logic [LINE_W-1:0] i_data;
    logic              d_readmiss = 1'b0, d_writethru = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [WORD_W-1:0] d_wdata = '0;
    logic              d_readready, d_writeready;
    logic [LINE_W-1:0] d_data;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ready = 1'b0;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              busy;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .WORD_W(WORD_W), .STARVE_MAX(STARVE_MAX)) dut (
        .Clk(Clk), .Rst(Rst),
        .i_readmiss(i_readmiss), .i_abort(i_abort), .i_addr(i_addr),
        .i_readready(i_readready), .i_data(i_data),
        .d_readmiss(d_readmiss), .d_writethru(d_writethru), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_readready(d_readready), .d_writeready(d_writeready), .d_data(d_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [1:0]        kind;   // 0 = i read, 1 = d read, 2 = d write
        logic [LINE_W-1:0] data;
    } resp_t;
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } cmd_t;

    resp_t             resp_q[$];
    cmd_t              cmd_q[$];
    int                errors = 0;
    int                checks = 0;
    int                cmd_count = 0;
    int                mem_lat = 3;
    bit                auto_drop = 1'b1;
    logic [ADDR_W-1:0] d_rd_addr = '0;

    function automatic logic [LINE_W-1:0] line_for(input logic [ADDR_W-1:0] a);
        if (a == 32'h0040_0040) return {4{32'hAAAA_AAAA}};
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'h0123_4567};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return i_readready;
            1:       return d_readready;
            2:       return d_writeready;
            3:       return mem_ready;
            default: return mem_req;
        endcase
    endfunction

    task automatic wait_pulse(input int which, input int maxc, input string name);
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            #1;
            n++;
        end while (!sig_of(which) && n < maxc);
        checks++;
        if (!sig_of(which)) begin
            errors++;
            $display("FAIL timeout_%s: waited %0d cycles, required event within %0d", name, n, maxc);
        end
    endtask

    task automatic push_cmd(input logic we, input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] w);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = w;
        cmd_q.push_back(c);
    endtask

    task automatic push_resp(input logic [1:0] k, input logic [LINE_W-1:0] d);
        resp_t r;
        r.kind = k; r.data = d;
        resp_q.push_back(r);
    endtask

    // Memory model: answer each new command after mem_lat cycles
    task automatic responder();
        forever begin
            @(negedge Clk);
            if (mem_req && !Rst) begin
                logic [ADDR_W-1:0] a;
                a = mem_addr;
                repeat (mem_lat) @(negedge Clk);
                mem_ready = 1'b1;
                mem_rdata = line_for(a);
                @(negedge Clk);
                mem_ready = 1'b0;
                mem_rdata = {4{32'hBAD0_BAD0}};
            end
        end
    endtask

    task automatic monitor();
        logic        prev_req;
        int          n;
        logic [1:0]  kind;
        logic [LINE_W-1:0] data;
        cmd_t        ce;
        resp_t       re;
        prev_req = 1'b0;
        forever begin
            @(negedge Clk);
            if (mem_req && !prev_req) begin
                cmd_count++;
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected: got addr %h we %0d, required no command", mem_addr, mem_we);
                end else begin
                    ce = cmd_q.pop_front();
                    check("cmd_we_addr", {mem_we, mem_addr}, {ce.we, ce.addr});
                    if (ce.we) check("cmd_wdata", mem_wdata, ce.wdata);
                end
            end
            prev_req = mem_req;
            n = int'(i_readready) + int'(d_readready) + int'(d_writeready);
            if (n > 0) begin
                kind = i_readready ? 2'd0 : (d_readready ? 2'd1 : 2'd2);
                data = i_readready ? i_data : (d_readready ? d_data : '0);
                if (n > 1) check("resp_onehot", n, 1);
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected: got kind %0d, required no response", kind);
                end else begin
                    re = resp_q.pop_front();
                    check("resp_kind", kind, re.kind);
                    check("resp_data", data, re.data);
                end
                if (auto_drop) begin
                    if (i_readready) i_readmiss = 1'b0;
                    if (d_readready) d_readmiss = 1'b0;
                    if (d_writeready) begin
                        d_writethru = 1'b0;
                        d_addr      = d_rd_addr;
                    end
                end
            end
        end
    endtask

    initial begin
        int c0;
        fork
            responder();
            monitor();
        join_none

        // Reset values
        repeat (3) @(negedge Clk);
        check("reset_ctrl", {mem_req, mem_we, busy, i_readready, d_readready, d_writeready}, 6'b0);
        check("reset_cmd", {mem_addr, mem_wdata}, 64'h0);
        check("reset_data", {i_data, d_data}, 256'h0);
        Rst = 1'b0;
        @(negedge Clk);
        check("idle_busy", busy, 1'b0);

        // Reset in the middle of a dcache read
        mem_lat = 5;
        push_cmd(1'b0, 32'h1001_0100, 32'h0);
        d_addr = 32'h1001_0100; d_readmiss = 1'b1;
        wait_pulse(4, 10, "rst_grant");
        repeat (2) @(negedge Clk);
        Rst = 1'b1; d_readmiss = 1'b0;
        #1;
        check("rst_mid_req_busy", {mem_req, busy}, 2'b00);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (8) @(negedge Clk);
        check("rst_mid_ddata", d_data, 128'h0);

        // Single icache miss
        push_cmd(1'b0, 32'h0040_0040, 32'h0);
        push_resp(2'd0, {4{32'hAAAA_AAAA}});
        i_addr = 32'h0040_0040; i_readmiss = 1'b1;
        @(negedge Clk);
        check("i_req_next_cycle", {mem_req, mem_we, busy}, 3'b101);
        wait_pulse(0, 20, "i_readready");
        @(negedge Clk);
        check("i_back_idle", {busy, mem_req}, 2'b00);

        // Simultaneous write-through, dcache read and icache read
        mem_lat = 2;
        d_rd_addr = 32'h1001_0000;
        push_cmd(1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
        push_cmd(1'b0, 32'h1001_0000, 32'h0);
        push_cmd(1'b0, 32'h0040_0080, 32'h0);
        push_resp(2'd2, '0);
        push_resp(2'd1, line_for(32'h1001_0000));
        push_resp(2'd0, line_for(32'h0040_0080));
        d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF; d_writethru = 1'b1;
        d_readmiss = 1'b1; i_addr = 32'h0040_0080; i_readmiss = 1'b1;
        wait_pulse(0, 60, "order_i");
        repeat (2) @(negedge Clk);

        // Starvation: dcache keeps both requests up while icache waits
        mem_lat = 1; auto_drop = 1'b0;
        d_addr = 32'h1002_0000; d_wdata = 32'h1111_2222;
        for (int k = 0; k < 2; k++) begin
            push_cmd(1'b1, 32'h1002_0000, 32'h1111_2222);
            push_resp(2'd2, '0);
            push_cmd(1'b0, 32'h1002_0000, 32'h0);
            push_resp(2'd1, line_for(32'h1002_0000));
        end
        push_cmd(1'b0, 32'h0040_0100, 32'h0);
        push_resp(2'd0, line_for(32'h0040_0100));
        i_addr = 32'h0040_0100;
        d_writethru = 1'b1; d_readmiss = 1'b1; i_readmiss = 1'b1;
        wait_pulse(0, 100, "starve_i");
        d_writethru = 1'b0; d_readmiss = 1'b0; i_readmiss = 1'b0;
        auto_drop = 1'b1;
        repeat (3) @(negedge Clk);

        // Abort during icache read with a dcache read pending
        mem_lat = 6;
        push_cmd(1'b0, 32'h0040_0200, 32'h0);
        push_cmd(1'b0, 32'h1003_0000, 32'h0);
        push_resp(2'd1, line_for(32'h1003_0000));
        i_addr = 32'h0040_0200; i_readmiss = 1'b1;
        wait_pulse(4, 10, "abort_grant");
        @(negedge Clk);
        d_addr = 32'h1003_0000; d_readmiss = 1'b1;
        @(negedge Clk);
        i_abort = 1'b1; i_readmiss = 1'b0;
        @(negedge Clk);
        i_abort = 1'b0;
        check("drain_req_busy", {mem_req, busy}, 2'b11);
        wait_pulse(3, 20, "drain_ready");
        @(negedge Clk);
        check("drain_idle", {mem_req, busy}, 2'b00);
        @(negedge Clk);
        check("drain_next_grant", {mem_req, mem_addr}, {1'b1, 32'h1003_0000});
        wait_pulse(1, 20, "abort_d_readready");
        repeat (2) @(negedge Clk);

        // Re-grant guard: dcache holds its request one cycle past the ready pulse
        mem_lat = 2; auto_drop = 1'b0;
        c0 = cmd_count;
        push_cmd(1'b0, 32'h1004_0000, 32'h0);
        push_resp(2'd1, line_for(32'h1004_0000));
        d_addr = 32'h1004_0000; d_readmiss = 1'b1;
        wait_pulse(1, 20, "guard_d_readready");
        @(negedge Clk);
        d_readmiss = 1'b0;
        auto_drop = 1'b1;
        repeat (6) @(negedge Clk);
        check("guard_one_cmd", cmd_count - c0, 1);

        check("cmd_q_drained", cmd_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
